// File: rtl/dcache_pkg.sv
// Shared geometry defaults and types for the set-associative D-cache storage array.
package dcache_pkg;

  localparam int DEF_NUM_WAYS = 4;
  localparam int DEF_NUM_SETS = 8;
  localparam int DEF_BLOCK_W  = 64;
  localparam int DEF_WORD_W   = 32;
  localparam int DEF_TAG_W    = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } flush_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [DEF_TAG_W-1:0] tag;
  } dcache_line_t;

endpackage

// File: rtl/dcache_array_plru.sv
// Tree pseudo-LRU for one set: node 0 is the root, children of node n are 2n+1 / 2n+2,
// a 0 bit sends the victim search left, and a touch points every node on its path away.
module plru_tree #(
  parameter int NUM_WAYS = 4,
  localparam int WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] i_bits,
  input  logic [WAY_W-1:0]    i_way,
  output logic [WAY_W-1:0]    o_victim,
  output logic [NUM_WAYS-2:0] o_bits
);

  // Victim and update live in separate processes so o_victim never depends on i_way.
  always_comb begin
    int   node;
    logic b;
    o_victim = '0;
    node     = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b                     = i_bits[node];
      o_victim[WAY_W-1-l]   = b;
      node                  = 2 * node + 1 + int'(b);
    end
  end

  always_comb begin
    int   node;
    logic b;
    o_bits = i_bits;
    node   = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b            = i_way[WAY_W-1-l];
      o_bits[node] = ~b;
      node         = 2 * node + 1 + int'(b);
    end
  end

endmodule

// File: rtl/dcache_array.sv
// Flop-based set-associative D-cache array: CAM lookups, invalid-first/PLRU victim choice,
// and a flush engine that offers dirty lines over a valid/ready writeback port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_WAYS = DEF_NUM_WAYS,
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int BLOCK_W  = DEF_BLOCK_W,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int TAG_W    = DEF_TAG_W,
  localparam int IDX_W   = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  localparam int WAY_W   = $clog2(NUM_WAYS),
  localparam int NWORDS  = BLOCK_W / WORD_W,
  localparam int OFF_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   rd_set_idx,
  input  logic [TAG_W-1:0]   rd_tag,
  input  logic [OFF_W-1:0]   rd_offset,
  output logic               rd_hit,
  output logic [WORD_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_set_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_data,
  input  logic               wr_dirty,
  output logic               wr_hit,
  output logic [WAY_W-1:0]   wr_way,
  output logic               victim_valid,
  output logic               victim_dirty,
  output logic [TAG_W-1:0]   victim_tag,
  output logic [BLOCK_W-1:0] victim_block,
  input  logic               flush_req,
  input  logic               flush_inval,
  output logic               flush_busy,
  output logic               flush_done,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [IDX_W-1:0]   wb_set_idx,
  output logic [TAG_W-1:0]   wb_tag,
  output logic [BLOCK_W-1:0] wb_block,
  output flush_state_t       dbg_flush_state
);

  logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
  logic [NUM_WAYS-1:0] r_dirty [NUM_SETS];
  logic [NUM_WAYS-2:0] r_plru  [NUM_SETS];
  logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
  logic [BLOCK_W-1:0]  r_data  [NUM_SETS][NUM_WAYS];

  flush_state_t        r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_ptr_set;
  logic [WAY_W-1:0]    r_ptr_way;
  logic                r_inval;

  logic [NUM_WAYS-1:0] w_rd_match, w_wr_match, w_invalid;
  logic [WAY_W-1:0]    w_rd_way, w_plru_victim;
  logic [NUM_WAYS-2:0] w_plru_wr_bits, w_rd_bits, w_wr_bits;
  logic [BLOCK_W-1:0]  w_rd_block;
  logic                w_last, w_line_dirty, w_advance, w_clr_valid, w_clr_dirty;

  function automatic logic [WAY_W-1:0] f_lowest(input logic [NUM_WAYS-1:0] v);
    f_lowest = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = WAY_W'(i);
    end
  endfunction

  function automatic logic [NUM_WAYS-2:0] f_touch(input logic [NUM_WAYS-2:0] bits,
                                                  input logic [WAY_W-1:0] way);
    int   node;
    logic b;
    f_touch = bits;
    node    = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b             = way[WAY_W-1-l];
      f_touch[node] = ~b;
      node          = 2 * node + 1 + int'(b);
    end
  endfunction

  always_comb begin
    w_rd_match = '0;
    w_wr_match = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_rd_match[w] = r_valid[rd_set_idx][w] && (r_tag[rd_set_idx][w] == rd_tag);
      w_wr_match[w] = r_valid[wr_set_idx][w] && (r_tag[wr_set_idx][w] == wr_tag);
    end
  end

  assign flush_busy = (r_state != IDLE);
  assign flush_done = (r_state == DONE);
  assign wb_valid   = (r_state == WB);
  assign dbg_flush_state = r_state;

  assign w_rd_way   = f_lowest(w_rd_match);
  assign rd_hit     = (|w_rd_match) && !flush_busy;
  assign w_rd_block = r_data[rd_set_idx][w_rd_way];

  always_comb begin
    rd_data = '0;
    if (rd_hit && (int'(rd_offset) < NWORDS)) rd_data = w_rd_block[int'(rd_offset) * WORD_W +: WORD_W];
  end

  assign w_invalid = ~r_valid[wr_set_idx];
  assign wr_hit    = |w_wr_match;
  assign wr_way    = wr_hit        ? f_lowest(w_wr_match) :
                     (|w_invalid)  ? f_lowest(w_invalid)  : w_plru_victim;

  assign victim_valid = r_valid[wr_set_idx][wr_way];
  assign victim_dirty = r_dirty[wr_set_idx][wr_way];
  assign victim_tag   = r_tag[wr_set_idx][wr_way];
  assign victim_block = r_data[wr_set_idx][wr_way];

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .i_bits   (r_plru[wr_set_idx]),
    .i_way    (wr_way),
    .o_victim (w_plru_victim),
    .o_bits   (w_plru_wr_bits)
  );

  // Same-set read and write: the write touch is layered on top of the read-updated bits.
  assign w_rd_bits = f_touch(r_plru[rd_set_idx], w_rd_way);
  assign w_wr_bits = (rd_en && rd_hit && (rd_set_idx == wr_set_idx)) ?
                     f_touch(w_rd_bits, wr_way) : w_plru_wr_bits;

  assign wb_set_idx   = r_ptr_set;
  assign wb_tag       = r_tag[r_ptr_set][r_ptr_way];
  assign wb_block     = r_data[r_ptr_set][r_ptr_way];
  assign w_line_dirty = r_valid[r_ptr_set][r_ptr_way] && r_dirty[r_ptr_set][r_ptr_way];
  assign w_last       = (r_ptr_set == IDX_W'(NUM_SETS - 1)) && (r_ptr_way == WAY_W'(NUM_WAYS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    w_clr_valid = 1'b0;
    w_clr_dirty = 1'b0;
    case (r_state)
      IDLE: if (flush_req) w_state_nxt = SCAN;
      SCAN: begin
        if (w_line_dirty) begin
          w_state_nxt = WB;
        end else begin
          w_advance   = 1'b1;
          w_clr_valid = r_inval;
          if (w_last) w_state_nxt = DONE;
        end
      end
      WB: begin
        if (wb_ready) begin
          w_advance   = 1'b1;
          w_clr_dirty = 1'b1;
          w_clr_valid = r_inval;
          w_state_nxt = w_last ? DONE : SCAN;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_ptr_set <= '0;
      r_ptr_way <= '0;
      r_inval   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && flush_req) begin
        r_ptr_set <= '0;
        r_ptr_way <= '0;
        r_inval   <= flush_inval;
      end else if (w_advance) begin
        r_ptr_way <= r_ptr_way + 1'b1;
        if (r_ptr_way == WAY_W'(NUM_WAYS - 1)) r_ptr_set <= r_ptr_set + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      if (!flush_busy) begin
        if (rd_en && rd_hit) r_plru[rd_set_idx] <= w_rd_bits;
        if (wr_en) begin
          r_plru[wr_set_idx]          <= w_wr_bits;
          r_valid[wr_set_idx][wr_way] <= 1'b1;
          r_dirty[wr_set_idx][wr_way] <= wr_dirty;
        end
      end
      if (w_clr_valid) r_valid[r_ptr_set][r_ptr_way] <= 1'b0;
      if (w_clr_dirty) r_dirty[r_ptr_set][r_ptr_way] <= 1'b0;
    end
  end

  // Tag and data carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clock) begin
    if (wr_en && !flush_busy) begin
      r_tag[wr_set_idx][wr_way]  <= wr_tag;
      r_data[wr_set_idx][wr_way] <= wr_data;
    end
  end

endmodule

// File: tb/tb_dcache_array.sv
// Directed bench for dcache_array: lookups, victim choice, PLRU order, flush and reset.
module tb_dcache_array;
  import dcache_pkg::*;

  localparam int IDX_W   = 3;
  localparam int TAG_W   = 26;
  localparam int WAY_W   = 2;
  localparam int OFF_W   = 1;
  localparam int BLOCK_W = 64;
  localparam int WORD_W  = 32;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               rd_en, wr_en, wr_dirty, flush_req, flush_inval, wb_ready;
  logic [IDX_W-1:0]   rd_set_idx, wr_set_idx;
  logic [TAG_W-1:0]   rd_tag, wr_tag;
  logic [OFF_W-1:0]   rd_offset;
  logic [BLOCK_W-1:0] wr_data;
  logic               rd_hit, wr_hit, victim_valid, victim_dirty;
  logic [WORD_W-1:0]  rd_data;
  logic [WAY_W-1:0]   wr_way;
  logic [TAG_W-1:0]   victim_tag, wb_tag;
  logic [BLOCK_W-1:0] victim_block, wb_block;
  logic               flush_busy, flush_done, wb_valid;
  logic [IDX_W-1:0]   wb_set_idx;
  flush_state_t       dbg_flush_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  logic [IDX_W+TAG_W-1:0] exp_q[$];
  logic [BLOCK_W-1:0]     exp_blk_q[$];

  always #5 clock = ~clock;

  dcache_array dut (
    .clock(clock), .reset(reset),
    .rd_en(rd_en), .rd_set_idx(rd_set_idx), .rd_tag(rd_tag), .rd_offset(rd_offset),
    .rd_hit(rd_hit), .rd_data(rd_data),
    .wr_en(wr_en), .wr_set_idx(wr_set_idx), .wr_tag(wr_tag), .wr_data(wr_data),
    .wr_dirty(wr_dirty), .wr_hit(wr_hit), .wr_way(wr_way),
    .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag), .victim_block(victim_block),
    .flush_req(flush_req), .flush_inval(flush_inval), .flush_busy(flush_busy),
    .flush_done(flush_done), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_set_idx(wb_set_idx), .wb_tag(wb_tag), .wb_block(wb_block),
    .dbg_flush_state(dbg_flush_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] blk(input logic [7:0] s, input logic [7:0] w);
    return {8'hB0, s, w, 8'h01, 8'hA0, s, w, 8'h00};
  endfunction

  task automatic idle_inputs();
    rd_en = 0; rd_set_idx = '0; rd_tag = '0; rd_offset = '0;
    wr_en = 0; wr_set_idx = '0; wr_tag = '0; wr_data = '0; wr_dirty = 0;
    flush_req = 0; flush_inval = 0; wb_ready = 0;
  endtask

  task automatic do_reset();
    @(posedge clock); #2 reset = 0;
    @(posedge clock); #1 reset = 1;
  endtask

  task automatic do_write(input logic [IDX_W-1:0] s, input logic [TAG_W-1:0] t,
                          input logic [63:0] d, input logic dirty);
    wr_set_idx = s; wr_tag = t; wr_data = d; wr_dirty = dirty; wr_en = 1;
    @(posedge clock); #1 wr_en = 0;
  endtask

  task automatic read_touch(input logic [IDX_W-1:0] s, input logic [TAG_W-1:0] t);
    rd_set_idx = s; rd_tag = t; rd_en = 1;
    @(posedge clock); #1 rd_en = 0;
  endtask

  task automatic probe_rd(input logic [IDX_W-1:0] s, input logic [TAG_W-1:0] t,
                          input logic [OFF_W-1:0] o);
    rd_set_idx = s; rd_tag = t; rd_offset = o; #1;
  endtask

  task automatic probe_wr(input logic [IDX_W-1:0] s, input logic [TAG_W-1:0] t);
    wr_en = 0; wr_set_idx = s; wr_tag = t; #1;
  endtask

  // Counts cycles (starting at 1) until flush_done, scoring each wb handshake seen on the way.
  task automatic wait_done(output int n);
    logic [IDX_W+TAG_W-1:0] e;
    n = 1;
    while (!flush_done && n < 500) begin
      if (wb_valid && wb_ready) begin
        if (exp_q.size() == 0) check("wb_extra", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("wb_line", 64'({wb_set_idx, wb_tag}), 64'(e));
          check("wb_block", wb_block, exp_blk_q.pop_front());
        end
      end
      @(posedge clock); #1;
      n++;
    end
    check("flush_done_seen", 64'(flush_done), 64'(1));
    check("wb_count_left", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    #12;
    check("rst_rd_hit", 64'(rd_hit), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    check("rst_wr_hit", 64'(wr_hit), 64'(0));
    check("rst_wr_way", 64'(wr_way), 64'(0));
    check("rst_victim_valid", 64'(victim_valid), 64'(0));
    check("rst_victim_dirty", 64'(victim_dirty), 64'(0));
    check("rst_wb_valid", 64'(wb_valid), 64'(0));
    check("rst_busy", 64'(flush_busy), 64'(0));
    check("rst_done", 64'(flush_done), 64'(0));
    @(posedge clock); #1 reset = 1;

    // Set 3 filled ways 0..3; word 1 of a block is its upper 32 bits.
    for (int w = 0; w < 4; w++) do_write(3'd3, TAG_W'(8'h10 + w), blk(8'd3, 8'(w)), 1'b0);
    probe_rd(3'd3, 26'h12, 1'b1);
    check("rd_hit_t12", 64'(rd_hit), 64'(1));
    check("rd_data_t12_w1", 64'(rd_data), 64'h0000_0000_B003_0201);
    probe_rd(3'd3, 26'h12, 1'b0);
    check("rd_data_t12_w0", 64'(rd_data), 64'h0000_0000_A003_0200);
    probe_rd(3'd3, 26'h14, 1'b1);
    check("rd_miss_hit", 64'(rd_hit), 64'(0));
    check("rd_miss_data", 64'(rd_data), 64'(0));

    // Invalid ways are taken lowest-first before any PLRU choice.
    probe_wr(3'd5, 26'hA);
    check("s5_way_first", 64'(wr_way), 64'(0));
    check("s5_victim_valid", 64'(victim_valid), 64'(0));
    do_write(3'd5, 26'hA, blk(8'd5, 8'd0), 1'b0);
    probe_wr(3'd5, 26'hB);
    check("s5_way_second", 64'(wr_way), 64'(1));
    do_write(3'd5, 26'hB, blk(8'd5, 8'd1), 1'b0);
    probe_wr(3'd5, 26'hA);
    check("s5_hit_a", 64'(wr_hit), 64'(1));
    check("s5_hit_way", 64'(wr_way), 64'(0));

    // PLRU on set 0: after fill the bits are 000; touches 0,1,2 leave root=0,left=0 -> way 0;
    // one more touch of way 0 sets root=1 while right node still points at 3.
    for (int w = 0; w < 4; w++) do_write(3'd0, TAG_W'(8'h40 + w), blk(8'd0, 8'(w)), (w == 3));
    read_touch(3'd0, 26'h40);
    read_touch(3'd0, 26'h41);
    read_touch(3'd0, 26'h42);
    probe_wr(3'd0, 26'h99);
    check("plru_miss_hit", 64'(wr_hit), 64'(0));
    check("plru_way_a", 64'(wr_way), 64'(0));
    check("plru_vtag_a", 64'(victim_tag), 64'h40);
    check("plru_vdirty_a", 64'(victim_dirty), 64'(0));
    read_touch(3'd0, 26'h40);
    probe_wr(3'd0, 26'h99);
    check("plru_way_b", 64'(wr_way), 64'(3));
    check("plru_vtag_b", 64'(victim_tag), 64'h43);
    check("plru_vdirty_b", 64'(victim_dirty), 64'(1));
    check("plru_vvalid_b", 64'(victim_valid), 64'(1));
    check("plru_vblock_b", victim_block, blk(8'd0, 8'd3));
    probe_wr(3'd0, 26'h41);
    check("plru_hit_way", 64'(wr_way), 64'(1));

    // Writeback flush without invalidate: 32 lines + 2 dirty + 1.
    do_reset();
    do_write(3'd1, 26'h20, blk(8'd1, 8'd0), 1'b0);
    do_write(3'd1, 26'h21, blk(8'd1, 8'd1), 1'b0);
    do_write(3'd1, 26'h22, blk(8'd1, 8'd2), 1'b1);
    do_write(3'd6, 26'h60, blk(8'd6, 8'd0), 1'b1);
    exp_q.push_back({3'd1, 26'h22}); exp_blk_q.push_back(blk(8'd1, 8'd2));
    exp_q.push_back({3'd6, 26'h60}); exp_blk_q.push_back(blk(8'd6, 8'd0));
    wb_ready = 1; flush_inval = 0; flush_req = 1;
    @(posedge clock); #1 flush_req = 0;
    wait_done(cyc);
    check("flush_latency", 64'(cyc), 64'(35));
    @(posedge clock); #1;
    check("flush_idle_after", 64'(flush_busy), 64'(0));
    probe_wr(3'd1, 26'h22);
    check("fl_s1_hit", 64'(wr_hit), 64'(1));
    check("fl_s1_way", 64'(wr_way), 64'(2));
    check("fl_s1_valid", 64'(victim_valid), 64'(1));
    check("fl_s1_clean", 64'(victim_dirty), 64'(0));
    probe_wr(3'd6, 26'h60);
    check("fl_s6_hit", 64'(wr_hit), 64'(1));
    check("fl_s6_clean", 64'(victim_dirty), 64'(0));

    // Invalidating flush with the first writeback stalled for 10 cycles.
    do_reset();
    do_write(3'd2, 26'h30, blk(8'd2, 8'd0), 1'b0);
    do_write(3'd2, 26'h31, blk(8'd2, 8'd1), 1'b1);
    do_write(3'd7, 26'h70, blk(8'd7, 8'd0), 1'b1);
    wb_ready = 0; flush_inval = 1; flush_req = 1;
    @(posedge clock); #1 flush_req = 0; flush_inval = 0;
    for (int n = 0; n < 100 && !wb_valid; n++) begin
      @(posedge clock); #1;
    end
    check("stall_wb_valid", 64'(wb_valid), 64'(1));
    for (int i = 0; i < 10; i++) begin
      check("stall_set", 64'(wb_set_idx), 64'(2));
      check("stall_tag", 64'(wb_tag), 64'h31);
      check("stall_block", wb_block, blk(8'd2, 8'd1));
      if (i == 0) begin
        probe_rd(3'd7, 26'h70, 1'b0);
        check("busy_rd_hit", 64'(rd_hit), 64'(0));
        check("busy_flag", 64'(flush_busy), 64'(1));
        wr_set_idx = 3'd7; wr_tag = 26'h77; wr_data = blk(8'd7, 8'd7); wr_dirty = 1; wr_en = 1;
      end else begin
        wr_en = 0;
      end
      @(posedge clock); #1;
    end
    exp_q.push_back({3'd2, 26'h31}); exp_blk_q.push_back(blk(8'd2, 8'd1));
    exp_q.push_back({3'd7, 26'h70}); exp_blk_q.push_back(blk(8'd7, 8'd0));
    wb_ready = 1;
    wait_done(cyc);
    @(posedge clock); #1;
    probe_rd(3'd2, 26'h30, 1'b0);
    check("inv_s2_t30", 64'(rd_hit), 64'(0));
    probe_rd(3'd2, 26'h31, 1'b0);
    check("inv_s2_t31", 64'(rd_hit), 64'(0));
    probe_rd(3'd7, 26'h70, 1'b0);
    check("inv_s7_t70", 64'(rd_hit), 64'(0));
    probe_rd(3'd7, 26'h77, 1'b0);
    check("busy_write_ignored", 64'(rd_hit), 64'(0));
    probe_wr(3'd7, 26'h70);
    check("inv_s7_wr_hit", 64'(wr_hit), 64'(0));
    check("inv_s7_vvalid", 64'(victim_valid), 64'(0));

    // Asynchronous reset while stalled in WB.
    @(posedge clock); #1;
    do_write(3'd4, 26'h50, blk(8'd4, 8'd0), 1'b1);
    wb_ready = 0; flush_req = 1;
    @(posedge clock); #1 flush_req = 0;
    for (int n = 0; n < 100 && !wb_valid; n++) begin
      @(posedge clock); #1;
    end
    check("rwb_wb_valid", 64'(wb_valid), 64'(1));
    #3 reset = 0;
    #1;
    check("rwb_wb_drop", 64'(wb_valid), 64'(0));
    check("rwb_busy_drop", 64'(flush_busy), 64'(0));
    check("rwb_state", 64'(dbg_flush_state), 64'(IDLE));
    @(posedge clock); #1 reset = 1;
    probe_rd(3'd4, 26'h50, 1'b0);
    check("rwb_rd_miss", 64'(rd_hit), 64'(0));
    probe_wr(3'd4, 26'h50);
    check("rwb_wr_miss", 64'(wr_hit), 64'(0));
    check("rwb_vvalid", 64'(victim_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
